// File: rtl/vpcie_pkg.sv
// Shared types for the vpcie request engine: op codes, completion status,
// FIFO entry layout, engine FSM states and the byte-enable decoder.
package vpcie_pkg;

    localparam logic [7:0] OP_MEM_READ  = 8'h00;
    localparam logic [7:0] OP_MEM_WRITE = 8'h01;

    localparam logic [1:0] CPL_SC = 2'd0;
    localparam logic [1:0] CPL_UR = 2'd1;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  bar;
        logic [7:0]  width;
        logic [63:0] addr;
        logic [31:0] data;
    } req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_R,
        ST_CPL
    } eng_state_e;

    // Returns {aligned_ok, be}; be is meaningless when aligned_ok is 0.
    function automatic logic [4:0] decode_be(input logic [7:0] width, input logic [1:0] lsb);
        logic [4:0] r;
        r = '0;
        case (width)
            8'd1:    r = {1'b1, 4'b0001 << lsb};
            8'd2:    r = {~lsb[0], 4'b0011 << lsb};
            8'd4:    r = {(lsb == 2'b00), 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vpcie_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointers; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module vpcie_req_fifo
    import vpcie_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  req_entry_t data_i,
    output req_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    req_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push_ok, pop_ok;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        drop_o   = push_i && !push_ok;
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_ok};
        head_o   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vpcie_req_engine.sv
// Executes buffered vpcie request headers as single-word BAR bus accesses,
// returns read completions and emits one credit per retired request.
// Optional macro VPCIE_BAR_CHECK_EN: treat bar_i >= NUM_BARS as malformed.
module vpcie_req_engine
    import vpcie_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_BARS   = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              new_msg_i,
    input  logic [7:0]        op_i,
    input  logic [7:0]        bar_i,
    input  logic [7:0]        width_i,
    input  logic [63:0]       addr_i,
    input  logic [31:0]       word_data_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [2:0]        bus_bar_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              cpl_valid_o,
    input  logic              cpl_ready_i,
    output logic [1:0]        cpl_status_o,
    output logic [31:0]       cpl_data_o,
    output logic              credit_token_o,
    output logic              overflow_o
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vpcie_req_engine: FIFO_DEPTH must be a power of two >= 2");
    end
    if (NUM_BARS < 1 || NUM_BARS > 8) begin : g_bad_bars
        $error("vpcie_req_engine: NUM_BARS must be in 1..8");
    end
    if (ADDR_W < 1 || ADDR_W > 64) begin : g_bad_addr
        $error("vpcie_req_engine: ADDR_W must be in 1..64");
    end

    req_entry_t push_entry;
    req_entry_t head;
    logic       fifo_full, fifo_empty, fifo_drop;
    logic       retire;

    eng_state_e  state_q, state_d;
    logic [1:0]  cpl_status_q, cpl_status_d;
    logic [31:0] cpl_data_q, cpl_data_d;
    logic        credit_q;
    logic        overflow_q;

    logic [4:0] head_dec;
    logic [3:0] head_be;
    logic       head_aligned, head_bar_ok, head_ok;
    logic       head_is_read, head_is_write;
    logic       unused_head;

    assign push_entry = '{op: op_i, bar: bar_i, width: width_i,
                          addr: addr_i, data: word_data_i};

    vpcie_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (new_msg_i),
        .pop_i   (retire),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        head_dec      = decode_be(head.width, head.addr[1:0]);
        head_aligned  = head_dec[4];
        head_be       = head_dec[3:0];
`ifdef VPCIE_BAR_CHECK_EN
        head_bar_ok   = (head.bar < 8'(NUM_BARS));
`else
        head_bar_ok   = 1'b1;
`endif
        head_ok       = head_aligned && head_bar_ok;
        head_is_read  = (head.op == OP_MEM_READ);
        head_is_write = (head.op == OP_MEM_WRITE);
    end

    // Upper address/BAR bits are deliberately dropped on the local bus.
    assign unused_head = ^{head, fifo_full};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        cpl_status_d = cpl_status_q;
        cpl_data_d   = cpl_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if ((head_is_read || head_is_write) && head_ok) begin
                        state_d = ST_ISSUE;
                    end else if (head_is_write) begin
                        // malformed write: silently retire, no completion
                        retire = 1'b1;
                    end else begin
                        state_d      = ST_CPL;
                        cpl_status_d = CPL_UR;
                        cpl_data_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus_gnt_i) begin
                    if (head_is_write) begin
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                if (bus_rvalid_i) begin
                    state_d      = ST_CPL;
                    cpl_status_d = CPL_SC;
                    cpl_data_d   = bus_rdata_i;
                end
            end
            ST_CPL: begin
                if (cpl_ready_i) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cpl_status_q <= '0;
            cpl_data_q   <= '0;
            credit_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cpl_status_q <= cpl_status_d;
            cpl_data_q   <= cpl_data_d;
            credit_q     <= retire;
            overflow_q   <= overflow_q | fifo_drop;
        end
    end

    // Bus fields come straight from the FIFO head, which cannot change until retire.
    always_comb begin
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_bar_o    = '0;
        bus_addr_o   = '0;
        bus_be_o     = '0;
        bus_wdata_o  = '0;
        cpl_valid_o  = 1'b0;
        cpl_status_o = '0;
        cpl_data_o   = '0;
        if (state_q == ST_ISSUE) begin
            bus_req_o   = 1'b1;
            bus_we_o    = head_is_write;
            bus_bar_o   = head.bar[2:0];
            bus_addr_o  = head.addr[ADDR_W-1:0];
            bus_be_o    = head_be;
            bus_wdata_o = head.data;
        end
        if (state_q == ST_CPL) begin
            cpl_valid_o  = 1'b1;
            cpl_status_o = cpl_status_q;
            cpl_data_o   = cpl_data_q;
        end
    end

    assign credit_token_o = credit_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_vpcie_req_engine.sv
// Self-checking bench for vpcie_req_engine: table of single requests plus
// hand-written latency, backpressure, credit, overflow and reset sequences.
`timescale 1ns/1ps
module tb_vpcie_req_engine;
    import vpcie_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned NUM_BARS   = 6;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              new_msg_i;
    logic [7:0]        op_i, bar_i, width_i;
    logic [63:0]       addr_i;
    logic [31:0]       word_data_i;
    logic              bus_req_o, bus_we_o;
    logic [2:0]        bus_bar_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_be_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_gnt_i, bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic              cpl_valid_o, cpl_ready_i;
    logic [1:0]        cpl_status_o;
    logic [31:0]       cpl_data_o;
    logic              credit_token_o, overflow_o;

    vpcie_req_engine #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .NUM_BARS   (NUM_BARS)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .new_msg_i      (new_msg_i),
        .op_i           (op_i),
        .bar_i          (bar_i),
        .width_i        (width_i),
        .addr_i         (addr_i),
        .word_data_i    (word_data_i),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_bar_o      (bus_bar_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_rdata_i    (bus_rdata_i),
        .cpl_valid_o    (cpl_valid_o),
        .cpl_ready_i    (cpl_ready_i),
        .cpl_status_o   (cpl_status_o),
        .cpl_data_o     (cpl_data_o),
        .credit_token_o (credit_token_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks   = 0;
    int n_fail     = 0;
    int credit_cnt = 0;

    always @(negedge clk_i) begin
        if (credit_token_o === 1'b1) credit_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  bar;
        logic [7:0]  width;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_bus;
        logic        exp_we;
        logic [2:0]  exp_bar;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_cpl;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] op, input logic [7:0] bar,
                                input logic [7:0] width, input logic [63:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic eb, input logic ewe, input logic [2:0] ebar,
                                input logic [31:0] eaddr, input logic [3:0] ebe,
                                input logic ec, input logic [1:0] est, input logic [31:0] edata);
        vec_t v;
        v = '{op: op, bar: bar, width: width, addr: addr, wdata: wdata, rdata: rdata,
              exp_bus: eb, exp_we: ewe, exp_bar: ebar, exp_addr: eaddr, exp_be: ebe,
              exp_cpl: ec, exp_status: est, exp_data: edata};
        return v;
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".bus"},   {bus_req_o, bus_we_o, bus_bar_o, bus_be_o, bus_addr_o}, '0);
        check({nm, ".wdata"}, bus_wdata_o, '0);
        check({nm, ".cpl"},   {cpl_valid_o, cpl_status_o, cpl_data_o}, '0);
        check({nm, ".flags"}, {credit_token_o, overflow_o}, '0);
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] bar, input logic [7:0] width,
                        input logic [63:0] addr, input logic [31:0] data);
        op_i = op; bar_i = bar; width_i = width; addr_i = addr; word_data_i = data;
        new_msg_i = 1'b1;
        tick();
        new_msg_i = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!bus_req_o && n < 20) begin
            tick();
            n++;
        end
        check({nm, ".req_seen"}, bus_req_o, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        int    c0, n;
        tag = $sformatf("vec%0d", idx);
        c0  = credit_cnt;
        push(v.op, v.bar, v.width, v.addr, v.wdata);
        n = 0;
        while (!bus_req_o && !cpl_valid_o && credit_cnt == c0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".responded"}, (n < 20), 1'b1);
        check({tag, ".bus_req"}, bus_req_o, v.exp_bus);
        if (bus_req_o) begin
            check({tag, ".we"},   bus_we_o,   v.exp_we);
            check({tag, ".bar"},  bus_bar_o,  v.exp_bar);
            check({tag, ".addr"}, bus_addr_o, v.exp_addr);
            check({tag, ".be"},   bus_be_o,   v.exp_be);
            if (v.exp_we) check({tag, ".wdata"}, bus_wdata_o, v.wdata);
            bus_gnt_i = 1'b1;
            tick();
            bus_gnt_i = 1'b0;
            if (v.op == OP_MEM_READ) begin
                repeat (2) tick();
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = v.rdata;
                tick();
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = '0;
            end
        end
        n = 0;
        while (!cpl_valid_o && n < 6) begin
            tick();
            n++;
        end
        check({tag, ".cpl_valid"}, cpl_valid_o, v.exp_cpl);
        if (cpl_valid_o) begin
            check({tag, ".status"}, cpl_status_o, v.exp_status);
            check({tag, ".data"},   cpl_data_o,   v.exp_data);
            cpl_ready_i = 1'b1;
            tick();
            cpl_ready_i = 1'b0;
        end
        repeat (2) tick();
        check({tag, ".credits"}, credit_cnt - c0, 1);
        check({tag, ".idle"}, {bus_req_o, cpl_valid_o}, 2'b00);
    endtask

    initial begin
        int c0, k, n;
        rst_ni = 1'b0; new_msg_i = 1'b0; op_i = '0; bar_i = '0; width_i = '0;
        addr_i = '0; word_data_i = '0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        bus_rdata_i = '0; cpl_ready_i = 1'b0;

        //         op     bar  wid  addr                    wdata         rdata         bus we bar eaddr        be     cpl st      edata
        vecs[0]  = mk(8'h01, 8'd0, 8'd4, 64'h1000,              32'hDEADBEEF, 32'h0,        1, 1, 0, 32'h1000,    4'hF, 0, CPL_SC, 32'h0);
        vecs[1]  = mk(8'h00, 8'd1, 8'd1, 64'h2003,              32'h0,        32'h11223344, 1, 0, 1, 32'h2003,    4'h8, 1, CPL_SC, 32'h11223344);
        vecs[2]  = mk(8'h00, 8'd0, 8'd2, 64'h5,                 32'h0,        32'h0,        0, 0, 0, 32'h0,       4'h0, 1, CPL_UR, 32'h0);
        vecs[3]  = mk(8'h00, 8'd0, 8'd3, 64'h4,                 32'h0,        32'h0,        0, 0, 0, 32'h0,       4'h0, 1, CPL_UR, 32'h0);
        vecs[4]  = mk(8'h01, 8'd0, 8'd2, 64'h3,                 32'hFFFF,     32'h0,        0, 0, 0, 32'h0,       4'h0, 0, CPL_SC, 32'h0);
        vecs[5]  = mk(8'h02, 8'd0, 8'd4, 64'h0,                 32'h0,        32'h0,        0, 0, 0, 32'h0,       4'h0, 1, CPL_UR, 32'h0);
        vecs[6]  = mk(8'h00, 8'd2, 8'd2, 64'h3002,              32'h0,        32'hCAFEF00D, 1, 0, 2, 32'h3002,    4'hC, 1, CPL_SC, 32'hCAFEF00D);
        vecs[7]  = mk(8'h01, 8'd5, 8'd1, 64'h4001,              32'h0000AB00, 32'h0,        1, 1, 5, 32'h4001,    4'h2, 0, CPL_SC, 32'h0);
        vecs[8]  = mk(8'h00, 8'd0, 8'd4, 64'h6002,              32'h0,        32'h0,        0, 0, 0, 32'h0,       4'h0, 1, CPL_UR, 32'h0);
        vecs[9]  = mk(8'h01, 8'd4, 8'd4, 64'h0000_0001_0000_0010, 32'h5A5A5A5A, 32'h0,      1, 1, 4, 32'h10,      4'hF, 0, CPL_SC, 32'h0);
        vecs[10] = mk(8'h00, 8'd3, 8'd1, 64'h9001,              32'h0,        32'h0000BE00, 1, 0, 3, 32'h9001,    4'h2, 1, CPL_SC, 32'h0000BE00);
`ifdef VPCIE_BAR_CHECK_EN
        vecs[11] = mk(8'h00, 8'd7, 8'd4, 64'h8000,              32'h0,        32'h77777777, 0, 0, 0, 32'h0,       4'h0, 1, CPL_UR, 32'h0);
`else
        vecs[11] = mk(8'h00, 8'd7, 8'd4, 64'h8000,              32'h0,        32'h77777777, 1, 0, 7, 32'h8000,    4'hF, 1, CPL_SC, 32'h77777777);
`endif

        tick(); tick();
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();
        check_all_zero("after_reset");

        // latency: new_msg in cycle 0 -> bus_req in cycle 2, fields held under stall
        c0 = credit_cnt;
        push(8'h01, 8'd2, 8'd2, 64'hA002, 32'h12340000);
        check("lat.cycle1_req", bus_req_o, 1'b0);
        tick();
        check("lat.cycle2_req", bus_req_o, 1'b1);
        tick();
        check("stall.hold", {bus_req_o, bus_we_o, bus_bar_o, bus_be_o, bus_addr_o},
              {1'b1, 1'b1, 3'd2, 4'hC, 32'hA002});
        check("stall.wdata", bus_wdata_o, 32'h12340000);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        check("wr.credit_pulse", {credit_token_o, bus_req_o}, 2'b10);
        tick();
        check("wr.credit_end", credit_token_o, 1'b0);
        check("wr.credit_cnt", credit_cnt - c0, 1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // completion backpressure: data must stay stable while cpl_ready is low
        c0 = credit_cnt;
        push(8'h00, 8'd1, 8'd1, 64'h2003, 32'h0);
        wait_req("bp");
        check("bp.be", bus_be_o, 4'h8);
        bus_gnt_i = 1'b1; tick(); bus_gnt_i = 1'b0;
        repeat (2) tick();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11223344;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        check("bp.cpl0", {cpl_valid_o, cpl_status_o, cpl_data_o}, {1'b1, CPL_SC, 32'h11223344});
        tick();
        check("bp.cpl1", {cpl_valid_o, cpl_status_o, cpl_data_o}, {1'b1, CPL_SC, 32'h11223344});
        tick();
        check("bp.cpl2", {cpl_valid_o, cpl_status_o, cpl_data_o}, {1'b1, CPL_SC, 32'h11223344});
        check("bp.no_early_credit", credit_cnt - c0, 0);
        cpl_ready_i = 1'b1;
        tick();
        cpl_ready_i = 1'b0;
        check("bp.retired", {cpl_valid_o, credit_token_o}, 2'b01);
        tick();
        check("bp.single_credit", {credit_token_o, 32'(credit_cnt - c0)}, {1'b0, 32'd1});

        // back-to-back malformed writes retire on consecutive cycles
        c0 = credit_cnt;
        op_i = 8'h01; bar_i = 8'd0; width_i = 8'd3; addr_i = 64'h0; word_data_i = '0;
        new_msg_i = 1'b1;
        tick();
        tick();
        new_msg_i = 1'b0;
        check("b2b.credit0", credit_token_o, 1'b1);
        tick();
        check("b2b.credit1", credit_token_o, 1'b1);
        tick();
        check("b2b.credit2", {credit_token_o, bus_req_o, cpl_valid_o}, 3'b000);
        check("b2b.count", credit_cnt - c0, 2);

        // overflow: five pushes with grant held off, depth four
        check("ovf.clear_before", overflow_o, 1'b0);
        c0 = credit_cnt;
        for (int i = 0; i < 5; i++) push(8'h01, 8'd0, 8'd4, 64'(i * 32'h100), 32'(i));
        check("ovf.sticky", overflow_o, 1'b1);
        bus_gnt_i = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_req_o) begin
                if (k < 4) check($sformatf("ovf.addr%0d", k), bus_addr_o, 32'(k * 32'h100));
                k++;
            end
            tick();
        end
        bus_gnt_i = 1'b0;
        check("ovf.executed", k, 4);
        check("ovf.credits", credit_cnt - c0, 4);
        check("ovf.still_set", overflow_o, 1'b1);

        // reset while waiting for read data
        push(8'h00, 8'd1, 8'd4, 64'h40, 32'h0);
        wait_req("rst");
        bus_gnt_i = 1'b1; tick(); bus_gnt_i = 1'b0;
        tick();
        check("rst.in_wait", {bus_req_o, cpl_valid_o}, 2'b00);
        c0 = credit_cnt;
        rst_ni = 1'b0;
        tick();
        check_all_zero("rst.mid");
        rst_ni = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_req_o || cpl_valid_o) n++;
            tick();
        end
        check("rst.no_activity", n, 0);
        check("rst.no_credit", credit_cnt - c0, 0);

        // full FIFO: push coinciding with a pop is accepted
        c0 = credit_cnt;
        for (int i = 0; i < 4; i++) push(8'h01, 8'd0, 8'd4, 64'(i * 32'h10), 32'(i));
        op_i = 8'h01; bar_i = 8'd0; width_i = 8'd4; addr_i = 64'h40; word_data_i = 32'h4;
        new_msg_i = 1'b1;
        bus_gnt_i = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_req_o) begin
                if (k < 5) check($sformatf("fullpp.addr%0d", k), bus_addr_o, 32'(k * 32'h10));
                k++;
            end
            tick();
            new_msg_i = 1'b0;
        end
        bus_gnt_i = 1'b0;
        check("fullpp.executed", k, 5);
        check("fullpp.credits", credit_cnt - c0, 5);
        check("fullpp.no_overflow", overflow_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
